// File: rtl/mesi_snoop_ctrl.sv
// mesi_snoop_ctrl: multi-line MESI snoop controller.
// Holds MESI state, tag and data for NUM_LINES lines. It accepts bus snoops
// through a valid/ready handshake, runs a memory write-back when a Modified
// line is invalidated or shared, and then applies the MESI transition.
// Processor-side line updates are accepted only while idle and no snoop is
// being offered.
// Optional build macro MESI_SNOOP_STATS_EN adds a saturating wb_count output.
module mesi_snoop_ctrl #(
    parameter int NUM_LINES = 4,
    parameter int TAG_W     = 4,
    parameter int DATA_W    = 8,
    localparam int IDX_W    = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   snoop_valid,
    output logic                   snoop_ready,
    input  logic [1:0]             snoop_msg,
    input  logic [TAG_W-1:0]       snoop_tag,
    output logic                   snoop_done,
    output logic                   snoop_hit,
    output logic                   abt_mem_acs,
    output logic                   mem_wb_req,
    output logic [TAG_W-1:0]       mem_wb_tag,
    output logic [DATA_W-1:0]      mem_wb_data,
    input  logic                   mem_wb_ack,
    input  logic                   loc_we,
    output logic                   loc_ready,
    input  logic [IDX_W-1:0]       loc_idx,
    input  logic [1:0]             loc_state,
    input  logic [TAG_W-1:0]       loc_tag,
    input  logic [DATA_W-1:0]      loc_data,
    output logic [2*NUM_LINES-1:0] line_state
`ifdef MESI_SNOOP_STATS_EN
    ,
    output logic [15:0]            wb_count
`endif
);

    localparam logic [1:0] MESI_M = 2'b00;
    localparam logic [1:0] MESI_S = 2'b10;
    localparam logic [1:0] MESI_I = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_WB_REQ = 2'd2,
        ST_UPDATE = 2'd3
    } fsm_e;

    fsm_e               fsm_q, fsm_d;
    logic [1:0]         msg_q, msg_d;
    logic [TAG_W-1:0]   snp_tag_q, snp_tag_d;
    logic               hit_q, hit_d;
    logic [IDX_W-1:0]   hit_idx_q, hit_idx_d;

    logic [1:0]         line_st_q   [NUM_LINES];
    logic [1:0]         line_st_d   [NUM_LINES];
    logic [TAG_W-1:0]   line_tag_q  [NUM_LINES];
    logic [TAG_W-1:0]   line_tag_d  [NUM_LINES];
    logic [DATA_W-1:0]  line_data_q [NUM_LINES];
    logic [DATA_W-1:0]  line_data_d [NUM_LINES];

    logic               snoop_done_q, snoop_done_d;
    logic               snoop_hit_q, snoop_hit_d;
    logic               abt_q, abt_d;
    logic               wb_req_q, wb_req_d;
    logic [TAG_W-1:0]   wb_tag_q, wb_tag_d;
    logic [DATA_W-1:0]  wb_data_q, wb_data_d;

    logic [NUM_LINES-1:0] match_s;
    logic                 look_hit_s;
    logic [IDX_W-1:0]     look_idx_s;
    logic                 need_wb_s;

    // Tag compare against every valid line; the lowest matching index wins.
    always_comb begin
        look_idx_s = {IDX_W{1'b0}};
        for (int i = 0; i < NUM_LINES; i++) begin
            match_s[i] = (line_st_q[i] != MESI_I) && (line_tag_q[i] == snp_tag_q);
        end
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            look_idx_s = match_s[i] ? IDX_W'(i) : look_idx_s;
        end
        look_hit_s = |match_s;
        need_wb_s  = look_hit_s && msg_q[0] && (line_st_q[look_idx_s] == MESI_M);
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q <= ST_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            ST_IDLE: begin
                if (snoop_valid) begin
                    fsm_d = ST_LOOKUP;
                end else begin
                    fsm_d = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                if (need_wb_s) begin
                    fsm_d = ST_WB_REQ;
                end else begin
                    fsm_d = ST_UPDATE;
                end
            end
            ST_WB_REQ: begin
                if (mem_wb_ack) begin
                    fsm_d = ST_UPDATE;
                end else begin
                    fsm_d = ST_WB_REQ;
                end
            end
            ST_UPDATE: fsm_d = ST_IDLE;
            default:   fsm_d = ST_IDLE;
        endcase
    end

    // Datapath next values: snoop capture, lookup result, line array writes.
    always_comb begin
        msg_d     = msg_q;
        snp_tag_d = snp_tag_q;
        hit_d     = hit_q;
        hit_idx_d = hit_idx_q;
        line_st_d   = line_st_q;
        line_tag_d  = line_tag_q;
        line_data_d = line_data_q;
        case (fsm_q)
            ST_IDLE: begin
                if (snoop_valid) begin
                    msg_d     = snoop_msg;
                    snp_tag_d = snoop_tag;
                end else if (loc_we) begin
                    line_st_d[loc_idx]   = loc_state;
                    line_tag_d[loc_idx]  = loc_tag;
                    line_data_d[loc_idx] = loc_data;
                end else begin
                    msg_d = msg_q;
                end
            end
            ST_LOOKUP: begin
                hit_d     = look_hit_s;
                hit_idx_d = look_idx_s;
            end
            ST_WB_REQ: begin
                hit_d = hit_q;
            end
            ST_UPDATE: begin
                // rm shares the line, wm invalidates it; reads leave it alone.
                if (hit_q && msg_q[0]) begin
                    line_st_d[hit_idx_q] = msg_q[1] ? MESI_I : MESI_S;
                end else begin
                    hit_d = hit_q;
                end
            end
            default: begin
                hit_d = hit_q;
            end
        endcase
    end

    // Datapath registers and line arrays.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            msg_q     <= 2'b00;
            snp_tag_q <= {TAG_W{1'b0}};
            hit_q     <= 1'b0;
            hit_idx_q <= {IDX_W{1'b0}};
            for (int i = 0; i < NUM_LINES; i++) begin
                line_st_q[i]   <= MESI_I;
                line_tag_q[i]  <= {TAG_W{1'b0}};
                line_data_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            msg_q       <= msg_d;
            snp_tag_q   <= snp_tag_d;
            hit_q       <= hit_d;
            hit_idx_q   <= hit_idx_d;
            line_st_q   <= line_st_d;
            line_tag_q  <= line_tag_d;
            line_data_q <= line_data_d;
        end
    end

    // Output logic, computed from the next state so the outputs are flops.
    always_comb begin
        snoop_done_d = (fsm_d == ST_UPDATE);
        snoop_hit_d  = (fsm_d == ST_UPDATE) &&
                       ((fsm_q == ST_LOOKUP) ? look_hit_s : hit_q);
        abt_d        = (fsm_d == ST_WB_REQ) ||
                       ((fsm_d == ST_UPDATE) && (fsm_q == ST_WB_REQ));
        wb_req_d     = (fsm_d == ST_WB_REQ);
        if ((fsm_q == ST_LOOKUP) && (fsm_d == ST_WB_REQ)) begin
            wb_tag_d  = line_tag_q[look_idx_s];
            wb_data_d = line_data_q[look_idx_s];
        end else begin
            wb_tag_d  = wb_tag_q;
            wb_data_d = wb_data_q;
        end
    end

    // Output registers; reset drops the write-back request at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            snoop_done_q <= 1'b0;
            snoop_hit_q  <= 1'b0;
            abt_q        <= 1'b0;
            wb_req_q     <= 1'b0;
            wb_tag_q     <= {TAG_W{1'b0}};
            wb_data_q    <= {DATA_W{1'b0}};
        end else begin
            snoop_done_q <= snoop_done_d;
            snoop_hit_q  <= snoop_hit_d;
            abt_q        <= abt_d;
            wb_req_q     <= wb_req_d;
            wb_tag_q     <= wb_tag_d;
            wb_data_q    <= wb_data_d;
        end
    end

    assign snoop_ready = (fsm_q == ST_IDLE);
    assign loc_ready   = (fsm_q == ST_IDLE) && !snoop_valid;
    assign snoop_done  = snoop_done_q;
    assign snoop_hit   = snoop_hit_q;
    assign abt_mem_acs = abt_q;
    assign mem_wb_req  = wb_req_q;
    assign mem_wb_tag  = wb_tag_q;
    assign mem_wb_data = wb_data_q;

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_line_state
        assign line_state[2*g +: 2] = line_st_q[g];
    end

`ifdef MESI_SNOOP_STATS_EN
    logic [15:0] wb_cnt_q, wb_cnt_d;

    // Accepted write-back counter, saturating at all ones.
    always_comb begin
        if ((fsm_q == ST_WB_REQ) && mem_wb_ack && (wb_cnt_q != 16'hFFFF)) begin
            wb_cnt_d = wb_cnt_q + 16'd1;
        end else begin
            wb_cnt_d = wb_cnt_q;
        end
    end

    // Write-back counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wb_cnt_q <= 16'd0;
        end else begin
            wb_cnt_q <= wb_cnt_d;
        end
    end

    assign wb_count = wb_cnt_q;
`endif

endmodule

// File: tb/tb_mesi_snoop_ctrl.sv
// Directed bench for mesi_snoop_ctrl with a transaction-level MESI model.
module tb_mesi_snoop_ctrl;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        snoop_valid = 1'b0;
    logic        snoop_ready;
    logic [1:0]  snoop_msg = 2'b00;
    logic [3:0]  snoop_tag = 4'h0;
    logic        snoop_done, snoop_hit, abt_mem_acs, mem_wb_req;
    logic [3:0]  mem_wb_tag;
    logic [7:0]  mem_wb_data;
    logic        mem_wb_ack = 1'b0;
    logic        loc_we = 1'b0;
    logic        loc_ready;
    logic [1:0]  loc_idx = 2'd0;
    logic [1:0]  loc_state = 2'b11;
    logic [3:0]  loc_tag = 4'h0;
    logic [7:0]  loc_data = 8'h00;
    logic [7:0]  line_state;
`ifdef MESI_SNOOP_STATS_EN
    logic [15:0] wb_count;
`endif

    mesi_snoop_ctrl #(.NUM_LINES(4), .TAG_W(4), .DATA_W(8)) dut (
        .clock(clock), .reset_n(reset_n),
        .snoop_valid(snoop_valid), .snoop_ready(snoop_ready),
        .snoop_msg(snoop_msg), .snoop_tag(snoop_tag),
        .snoop_done(snoop_done), .snoop_hit(snoop_hit),
        .abt_mem_acs(abt_mem_acs), .mem_wb_req(mem_wb_req),
        .mem_wb_tag(mem_wb_tag), .mem_wb_data(mem_wb_data),
        .mem_wb_ack(mem_wb_ack), .loc_we(loc_we), .loc_ready(loc_ready),
        .loc_idx(loc_idx), .loc_state(loc_state), .loc_tag(loc_tag),
        .loc_data(loc_data), .line_state(line_state)
`ifdef MESI_SNOOP_STATS_EN
        , .wb_count(wb_count)
`endif
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Model: cache contents and the expected outputs for the current cycle.
    logic [1:0] m_state [4];
    logic [3:0] m_tag   [4];
    logic [7:0] m_data  [4];
    bit         check_en = 1'b0;
    bit         exp_ready, exp_done, exp_hit, exp_abt, exp_wbreq;
    logic [3:0] exp_wb_tag;
    logic [7:0] exp_wb_data;

    // Observed facts used by the literal checks.
    int         cyc = 0;
    int         hs_cyc = 0;
    int         last_lat = 0;
    logic       last_hit = 1'b0;
    logic [3:0] seen_wb_tag = 4'h0;
    logic [7:0] seen_wb_data = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_states();
        logic [7:0] p;
        for (int i = 0; i < 4; i++) p[2*i +: 2] = m_state[i];
        return p;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Per-cycle compare against the model, on the falling edge.
    always @(negedge clock) begin
        cyc++;
        if (snoop_valid && snoop_ready) hs_cyc = cyc;
        if (snoop_done) begin
            last_lat = cyc - hs_cyc + 1;
            last_hit = snoop_hit;
        end
        if (mem_wb_req) begin
            seen_wb_tag  = mem_wb_tag;
            seen_wb_data = mem_wb_data;
        end
        if (check_en) begin
            chk("line_state", {24'd0, line_state}, {24'd0, model_states()});
            chk("snoop_ready", {31'd0, snoop_ready}, {31'd0, exp_ready});
            chk("loc_ready", {31'd0, loc_ready}, {31'd0, exp_ready && !snoop_valid});
            chk("snoop_done", {31'd0, snoop_done}, {31'd0, exp_done});
            chk("abt_mem_acs", {31'd0, abt_mem_acs}, {31'd0, exp_abt});
            chk("mem_wb_req", {31'd0, mem_wb_req}, {31'd0, exp_wbreq});
            if (exp_done) chk("snoop_hit", {31'd0, snoop_hit}, {31'd0, exp_hit});
            if (exp_wbreq) begin
                chk("mem_wb_tag", {28'd0, mem_wb_tag}, {28'd0, exp_wb_tag});
                chk("mem_wb_data", {24'd0, mem_wb_data}, {24'd0, exp_wb_data});
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_state[i] = 2'b11;
            m_tag[i]   = 4'h0;
            m_data[i]  = 8'h00;
        end
        exp_ready = 1'b1; exp_done = 1'b0; exp_hit = 1'b0;
        exp_abt = 1'b0; exp_wbreq = 1'b0;
        exp_wb_tag = 4'h0; exp_wb_data = 8'h00;
    endtask

    task automatic local_write(input logic [1:0] idx, input logic [1:0] st,
                               input logic [3:0] tg, input logic [7:0] dt);
        loc_we = 1'b1; loc_idx = idx; loc_state = st; loc_tag = tg; loc_data = dt;
        step();
        loc_we = 1'b0;
        m_state[idx] = st; m_tag[idx] = tg; m_data[idx] = dt;
    endtask

    // One snoop; wb_cycles is the number of cycles the request waits in total.
    task automatic do_snoop(input logic [1:0] msg, input logic [3:0] tg,
                            input int wb_cycles, input bit with_loc);
        bit hit = 1'b0;
        int idx = 0;
        bit needs_wb;
        for (int i = 0; i < 4; i++) begin
            if (!hit && m_state[i] != 2'b11 && m_tag[i] == tg) begin
                hit = 1'b1;
                idx = i;
            end
        end
        needs_wb = hit && (msg == 2'b01 || msg == 2'b11) && m_state[idx] == 2'b00;
        snoop_valid = 1'b1; snoop_msg = msg; snoop_tag = tg;
        if (with_loc) loc_we = 1'b1;
        step();
        snoop_valid = 1'b0; loc_we = 1'b0; exp_ready = 1'b0;
        if (needs_wb) begin
            step();
            exp_wbreq = 1'b1; exp_abt = 1'b1;
            exp_wb_tag = m_tag[idx]; exp_wb_data = m_data[idx];
            repeat (wb_cycles - 1) step();
            mem_wb_ack = 1'b1;
            step();
            mem_wb_ack = 1'b0;
        end else begin
            step();
        end
        exp_wbreq = 1'b0; exp_done = 1'b1; exp_hit = hit; exp_abt = needs_wb;
        step();
        exp_done = 1'b0; exp_abt = 1'b0; exp_ready = 1'b1;
        if (hit && msg == 2'b01) m_state[idx] = 2'b10;
        if (hit && msg == 2'b11) m_state[idx] = 2'b11;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        #2;
        chk("reset_line_state", {24'd0, line_state}, 32'h0000_00FF);
        chk("reset_snoop_ready", {31'd0, snoop_ready}, 32'd1);
        chk("reset_mem_wb_req", {31'd0, mem_wb_req}, 32'd0);
        step();
        check_en = 1'b1;

        // E line snooped with rm: shared, no write-back, latency 3.
        local_write(2'd1, 2'b01, 4'h3, 8'h11);
        do_snoop(2'b01, 4'h3, 0, 1'b0);
        chk("rm_latency", last_lat, 32'd3);
        chk("rm_hit", {31'd0, last_hit}, 32'd1);
        chk("rm_line1", {30'd0, line_state[3:2]}, 32'd2);

        // M line snooped with wm, ack after 4 cycles: write-back then invalid.
        local_write(2'd2, 2'b00, 4'h5, 8'hA7);
        do_snoop(2'b11, 4'h5, 4, 1'b0);
        chk("wm_latency", last_lat, 32'd7);
        chk("wm_wb_tag", {28'd0, seen_wb_tag}, 32'h5);
        chk("wm_wb_data", {24'd0, seen_wb_data}, 32'hA7);
        chk("wm_line2", {30'd0, line_state[5:4]}, 32'd3);

        // rh hit on the S line, then wm miss: no state change.
        do_snoop(2'b00, 4'h3, 0, 1'b0);
        chk("rh_hit", {31'd0, last_hit}, 32'd1);
        chk("rh_line1", {30'd0, line_state[3:2]}, 32'd2);
        do_snoop(2'b11, 4'h9, 0, 1'b0);
        chk("miss_hit", {31'd0, last_hit}, 32'd0);
        chk("miss_latency", last_lat, 32'd3);

        // Collision: snoop wins, local write re-presented afterwards.
        loc_idx = 2'd3; loc_state = 2'b01; loc_tag = 4'h6; loc_data = 8'h66;
        do_snoop(2'b00, 4'h3, 0, 1'b1);
        chk("collide_line3", {30'd0, line_state[7:6]}, 32'd3);
        local_write(2'd3, 2'b01, 4'h6, 8'h66);
        chk("late_write_line3", {30'd0, line_state[7:6]}, 32'd1);

        // Reset while a write-back is pending.
        local_write(2'd0, 2'b00, 4'h7, 8'h3C);
        check_en = 1'b0;
        snoop_valid = 1'b1; snoop_msg = 2'b11; snoop_tag = 4'h7;
        step();
        snoop_valid = 1'b0;
        step();
        chk("pre_reset_wb_req", {31'd0, mem_wb_req}, 32'd1);
`ifdef MESI_SNOOP_STATS_EN
        chk("wb_count_one", {16'd0, wb_count}, 32'd1);
`endif
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_wb_req_drop", {31'd0, mem_wb_req}, 32'd0);
        chk("async_abt_drop", {31'd0, abt_mem_acs}, 32'd0);
        chk("async_line_state", {24'd0, line_state}, 32'h0000_00FF);
`ifdef MESI_SNOOP_STATS_EN
        chk("wb_count_reset", {16'd0, wb_count}, 32'd0);
`endif
        step();
        reset_n = 1'b1;
        model_reset();
        check_en = 1'b1;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
